// File: rtl/line_burst_adapter.sv
// line_burst_adapter
// Converts whole-line (256-bit) cache memory requests into a burst of four
// 64-bit beats on the main-memory bus and reassembles read beats into a line.
// One line transfer is in flight at a time; completion is a one-cycle resp_o.
//
// Handshake: the cache holds read_i/write_i (with address_i/line_i) until it
// sees resp_o; the request is accepted only in IDLE and its address/line are
// captured then, so later changes are ignored until the adapter returns to
// IDLE. Toward memory, read_o/write_o stay high for the whole burst and every
// cycle with resp_i high transfers exactly one beat, lowest 64 bits first.
// resp_i outside a burst is ignored. Every output is a register or a decode
// of registers, so no input reaches an output combinationally.
module line_burst_adapter #(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int s_beat   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [s_line-1:0] line_i,
    output logic [s_line-1:0] line_o,
    output logic              resp_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    output logic [s_beat-1:0] burst_o,
    input  logic [s_beat-1:0] burst_i,
    input  logic              resp_i,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        count_q, count_d;
    logic [s_line-1:0] buf_q, buf_d;
    logic [31:0]       addr_q, addr_d;

    // Next-state: request acceptance in IDLE, beat transfer in READ/WRITE
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                // Read wins a tie; a held write is picked up on a later IDLE cycle
                if (read_i) begin
                    state_d = READ;
                    count_d = 2'd0;
                    addr_d  = {address_i[31:s_offset], {s_offset{1'b0}}};
                end else if (write_i) begin
                    state_d = WRITE;
                    count_d = 2'd0;
                    addr_d  = {address_i[31:s_offset], {s_offset{1'b0}}};
                    buf_d   = line_i;
                end
            end
            READ: begin
                if (resp_i) begin
                    buf_d[count_q*s_beat +: s_beat] = burst_i;
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (resp_i) begin
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset aborts any burst without a response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= 2'd0;
            buf_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        line_o      = buf_q;
        address_o   = addr_q;
        read_o      = (state_q == READ);
        write_o     = (state_q == WRITE);
        resp_o      = (state_q == DONE);
        burst_o     = (state_q == WRITE) ? buf_q[count_q*s_beat +: s_beat] : '0;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: driver tasks issue bursts and push
// expected lines/beats into queues; a monitor pops and compares on resp_o and
// on every accepted write beat.
module tb_line_burst_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  address_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic [255:0] line_i = '0;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i = '0;
    logic         resp_i = 1'b0;
    logic [1:0]   dbg_state_o;

    logic [255:0] exp_q[$];
    logic [63:0]  exp_beat_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int resp_cnt = 0;

    localparam logic [255:0] LINE_R0 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE_R1 = {64'hdddd_0000_dddd_0004, 64'hcccc_0000_cccc_0003,
                                        64'hbbbb_0000_bbbb_0002, 64'haaaa_0000_aaaa_0001};
    localparam logic [255:0] LINE_W0 = {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
                                        64'h0f1e_2d3c_4b5a_6978, 64'h8796_a5b4_c3d2_e1f0};
    localparam logic [255:0] LINE_W1 = {64'h5555_aaaa_5555_aaaa, 64'h0000_ffff_0000_ffff,
                                        64'h1234_1234_1234_1234, 64'hcafe_f00d_beef_0001};

    // Clock
    always #5 clk = ~clk;

    line_burst_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .address_i   (address_i),
        .read_i      (read_i),
        .write_i     (write_i),
        .line_i      (line_i),
        .line_o      (line_o),
        .resp_o      (resp_o),
        .address_o   (address_o),
        .read_o      (read_o),
        .write_o     (write_o),
        .burst_o     (burst_o),
        .burst_i     (burst_i),
        .resp_i      (resp_i),
        .dbg_state_o (dbg_state_o)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_line_o"}, line_o, 256'(0));
        check({tag, "_resp_o"}, 256'(resp_o), 256'(0));
        check({tag, "_address_o"}, 256'(address_o), 256'(0));
        check({tag, "_read_o"}, 256'(read_o), 256'(0));
        check({tag, "_write_o"}, 256'(write_o), 256'(0));
        check({tag, "_burst_o"}, 256'(burst_o), 256'(0));
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents output
    always @(negedge clk) begin
        if (rst) begin
            if (resp_o) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got resp_o=1 want no response");
                end else begin
                    check("line_o", line_o, exp_q.pop_front());
                end
            end
            if (write_o && resp_i) begin
                if (exp_beat_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got burst_o=%h want no beat", burst_o);
                end else begin
                    check("burst_o", 256'(burst_o), 256'(exp_beat_q.pop_front()));
                end
            end
        end
    end

    // Read burst: pat bit k = resp_i in burst cycle k+1
    task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                           input logic [15:0] pat, input int nslots);
        int b;
        b = 0;
        read_i    = 1'b1;
        address_i = addr;
        tick();
        address_i = ~addr;
        for (int k = 0; k < nslots; k++) begin
            resp_i  = pat[k];
            burst_i = pat[k] ? line[b*64 +: 64] : 64'hdead_beef_dead_beef;
            if (pat[k] && b == 3) exp_q.push_back(line);
            @(negedge clk);
            check("rd_read_o", 256'(read_o), 256'(1));
            check("rd_write_o", 256'(write_o), 256'(0));
            check("rd_resp_o", 256'(resp_o), 256'(0));
            check("rd_address_o", 256'(address_o), 256'(addr & 32'hffff_ffe0));
            if (pat[k]) b++;
            tick();
        end
        resp_i  = 1'b0;
        burst_i = '0;
        @(negedge clk);
        check("rd_done_resp_o", 256'(resp_o), 256'(1));
        check("rd_done_read_o", 256'(read_o), 256'(0));
        tick();
        read_i    = 1'b0;
        address_i = '0;
        @(negedge clk);
        check("rd_resp_pulse", 256'(resp_o), 256'(0));
    endtask

    // Write burst: line_i is corrupted after acceptance to prove it was captured
    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input logic [15:0] pat, input int nslots);
        int b;
        b = 0;
        write_i   = 1'b1;
        address_i = addr;
        line_i    = line;
        tick();
        line_i    = ~line;
        address_i = ~addr;
        for (int k = 0; k < nslots; k++) begin
            resp_i  = pat[k];
            burst_i = 64'h0bad_0bad_0bad_0bad;
            if (pat[k]) begin
                exp_beat_q.push_back(line[b*64 +: 64]);
                if (b == 3) exp_q.push_back(line);
            end
            @(negedge clk);
            check("wr_write_o", 256'(write_o), 256'(1));
            check("wr_read_o", 256'(read_o), 256'(0));
            check("wr_resp_o", 256'(resp_o), 256'(0));
            check("wr_address_o", 256'(address_o), 256'(addr & 32'hffff_ffe0));
            if (pat[k]) b++;
            tick();
        end
        resp_i = 1'b0;
        @(negedge clk);
        check("wr_done_resp_o", 256'(resp_o), 256'(1));
        check("wr_done_write_o", 256'(write_o), 256'(0));
        tick();
        write_i   = 1'b0;
        address_i = '0;
        @(negedge clk);
        check("wr_resp_pulse", 256'(resp_o), 256'(0));
    endtask

    initial begin
        int cnt_before;
        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            read_i    = 1'($urandom_range(0, 1));
            write_i   = 1'($urandom_range(0, 1));
            resp_i    = 1'($urandom_range(0, 1));
            address_i = $urandom();
            burst_i   = {$urandom(), $urandom()};
            line_i    = {8{$urandom()}};
            @(negedge clk);
            check_all_zero("rst");
        end
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        address_i = '0; burst_i = '0; line_i = '0;
        rst = 1'b1;

        // Zero-wait read, then read with gaps in resp_i
        do_read(32'h1234_5678, LINE_R0, 16'b1111, 4);
        do_read(32'h8000_001f, LINE_R1, 16'b1011001, 7);

        // Zero-wait write, then write with gaps
        do_write(32'h0000_0040, LINE_W0, 16'b1111, 4);
        do_write(32'hffff_ffe5, LINE_W1, 16'b1010101, 7);

        // Read and write requested together: read first, write right after DONE
        write_i = 1'b1;
        line_i  = LINE_W1;
        do_read(32'h0000_1000, LINE_R1, 16'b1111, 4);
        do_write(32'h0000_2008, LINE_W0, 16'b1111, 4);

        // Stray resp_i while idle has no effect
        for (int i = 0; i < 3; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom(), $urandom()};
            @(negedge clk);
            check("idle_state", 256'(dbg_state_o), 256'(0));
            check("idle_read_o", 256'(read_o), 256'(0));
            check("idle_resp_o", 256'(resp_o), 256'(0));
            tick();
        end
        resp_i = 1'b0;

        // Reset after beat 2 of a read aborts it
        cnt_before = resp_cnt;
        read_i    = 1'b1;
        address_i = 32'h0000_3000;
        tick();
        for (int k = 0; k < 2; k++) begin
            resp_i  = 1'b1;
            burst_i = LINE_R0[k*64 +: 64];
            tick();
        end
        resp_i = 1'b0;
        read_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("abort_async");
        @(negedge clk);
        check_all_zero("abort_hold");
        tick();
        rst = 1'b1;
        tick();
        check("abort_no_resp", 256'(resp_cnt), 256'(cnt_before));
        do_read(32'h0000_3004, LINE_R0, 16'b1111, 4);

        tick();
        check("exp_q_drained", 256'(exp_q.size()), 256'(0));
        check("exp_beat_q_drained", 256'(exp_beat_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/line_burst_adapter.md
# line_burst_adapter

Downstream neighbour of the two-way cache: converts the cache's 256-bit whole-line memory requests into a burst of four 64-bit beats on the main-memory bus, and reassembles read beats into a full line. Sits between the cache's memory-side port and the DRAM/memory model. Handles one line transfer at a time and presents a single-cycle completion pulse back to the cache controller.

## Interface
- s_offset, 5: line offset bits; line = 2**s_offset bytes.
- s_line, 256: line width in bits (8 * 2**s_offset).
- s_beat, 64: memory beat width; beats = s_line / s_beat = 4.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- address_i  in  32  cache request address.
- read_i  in  1  cache line-read request, held until resp_o.
- write_i  in  1  cache line-write (writeback) request, held until resp_o.
- line_i  in  s_line  line to write; sampled at request acceptance only.
- line_o  out  s_line  assembled read line.
- resp_o  out  1  one-cycle completion pulse to cache.
- address_o  out  32  line-aligned memory address.
- read_o  out  1  memory burst read request.
- write_o  out  1  memory burst write request.
- burst_o  out  s_beat  current write beat.
- burst_i  in  s_beat  read beat from memory.
- resp_i  in  1  memory beat strobe; one beat transferred per cycle it is high.

## Operation
- States: IDLE, READ, WRITE, DONE. 2-bit beat counter, line buffer (s_line), address register.
- IDLE: on read_i=1 -> READ; else on write_i=1 -> WRITE. Read wins if both high; write stays pending and is accepted the cycle after DONE if still asserted.
- Acceptance (IDLE edge): address register <= {address_i[31:s_offset], s_offset'b0}; counter <= 0; on write, buffer <= line_i.
- READ: read_o=1. Each cycle resp_i=1: buffer[count*64 +: 64] <= burst_i, count++. On 4th beat -> DONE.
- WRITE: write_o=1, burst_o = buffer[count*64 +: 64]. Each cycle resp_i=1: count++. On 4th beat -> DONE.
- Beat order: lowest 64 bits first (beat 0 = line[63:0]).
- DONE: resp_o=1 for exactly one cycle, read_o=write_o=0, -> IDLE.
- resp_i in IDLE or DONE: ignored, no state change.
- address_o driven from address register; constant for the whole burst; 0 only after reset.
- line_o = buffer; valid from the resp_o cycle of a read until the next accepted request.
- read_i/write_i/address_i/line_i changes after acceptance are ignored until IDLE.
- Counter wraps 3->0 only on the final beat, coincident with leaving READ/WRITE.

## Timing
- All outputs registered or decoded from state; no combinational path from any input to any output.
- Reset (rst=0, asynchronous): state IDLE, count 0, buffer 0, address 0; line_o=0, resp_o=0, address_o=0, read_o=0, write_o=0, burst_o=0. Reset mid-burst aborts immediately; no resp_o issued.
- Cycle 0 = first cycle read_i/write_i high in IDLE. read_o/write_o rise in cycle 1.
- Beats accepted in any cycle ≥1 with resp_i=1; gaps in resp_i stall the counter, request stays asserted.
- Zero-wait memory (resp_i high cycles 1–4): resp_o in cycle 5; minimum latency 5 cycles; next request accepted cycle 6.
- General: resp_o one cycle after the 4th resp_i beat.
- Cache must drop read_i/write_i in the cycle after resp_o; a request still high then is treated as new.

## Test plan
- Reset: hold rst=0 with random inputs -> all outputs 0; release, read_i=1 at 0x1234_5678 -> address_o=0x1234_5660, read_o=1 next cycle.
- Read zero-wait: beats 0x00..11, 0x..22, 0x..33, 0x..44 on cycles 1–4 -> resp_o cycle 5 only, line_o={beat3,beat2,beat1,beat0}.
- Read with stalls: resp_i pattern 1,0,0,1,1,0,1 -> count advances on 1s only, resp_o one cycle after 7th cycle, read_o high throughout.
- Write: line_i=256'h0123…cdef, write_i=1, line_i changed after acceptance -> burst_o shows original line[63:0]..[255:192] on successive resp_i, resp_o after beat 4, write_o falls.
- Simultaneous read_i=write_i=1 -> read burst first, then write accepted cycle after DONE; stray resp_i in IDLE -> no effect.
- Reset asserted after beat 2 of a read -> outputs 0 immediately, no resp_o; subsequent read completes normally.
